// File: rtl/bus85_memif_if.sv
// bus85_memif_if: 8085 downstream bus signals shared between the core
// (master) and memory slave. The multiplexed AD bus is bidirectional and is
// carried as a separate inout port on the slave so that tristate resolution
// stays on a plain net.
interface bus85_memif_if;
  logic [7:0]  addr;    // A15..A8
  logic        ale;     // address latch enable, active high
  logic        iom_;    // 0 = memory cycle, 1 = I/O cycle
  logic        rd_;     // read strobe, active low
  logic        wr_;     // write strobe, active low
  logic        ready;   // 0 requests a wait state
  logic [15:0] adrlat;  // latched {A15..A8, AD7..AD0}
  logic        sel;     // cycle is a memory access inside the window

  modport slave  (input addr, ale, iom_, rd_, wr_, output ready, adrlat, sel);
  modport master (output addr, ale, iom_, rd_, wr_, input ready, adrlat, sel);
endinterface

// File: rtl/bus85_memif.sv
// bus85_memif: 8085 bus memory slave. Latches the address on ALE, decodes a
// 2**MEMLOG2 byte window at BASEADDR and serves reads/writes from an internal
// array. Wait-state generation through READY is compiled only when the macro
// BUS85MEM_WAIT_EN is defined; otherwise READY is tied high and WAITCYC is
// ignored.
module bus85_memif #(
  parameter logic [15:0] BASEADDR = 16'h0000,
  parameter int          MEMLOG2  = 10,
  parameter int          WAITCYC  = 2
) (
  input  logic             clk,
  input  logic             rst_,
  inout  wire  [7:0]       addrdata,
  bus85_memif_if.slave     bus
);

  localparam int DEPTH = 1 << MEMLOG2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
`ifdef BUS85MEM_WAIT_EN
    S_WAIT = 2'd2,
`endif
    S_XFER = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [15:0]          r_adrlat;
  logic                 r_sel;
  logic                 r_done;
  logic [7:0]           r_rdat;
  logic [7:0]           r_mem [0:DEPTH-1];

  logic [15:0]          w_adr_in;
  logic                 w_sel_in;
  logic                 w_strobe;
  logic                 w_wr_en;
  logic                 w_xfer_entry;
  logic                 w_oe;
  logic [MEMLOG2-1:0]   w_idx;

`ifdef BUS85MEM_WAIT_EN
  localparam logic [3:0] WAIT_LOAD = 4'(WAITCYC - 1);
  logic [3:0]           r_cnt;
  logic [3:0]           w_cnt_next;
  logic                 r_ready;
`else
  logic [3:0]           w_unused_waitcyc;
  assign w_unused_waitcyc = 4'(WAITCYC);
`endif

  // Incoming address and window decode are evaluated on the live bus so the
  // select flag is valid in the same edge that latches the address.
  assign w_adr_in = {bus.addr, addrdata};
  assign w_sel_in = !bus.iom_ && ((w_adr_in >> MEMLOG2) == (BASEADDR >> MEMLOG2));
  assign w_strobe = !bus.rd_ || !bus.wr_;
  assign w_idx    = r_adrlat[MEMLOG2-1:0];

  // A simultaneous rd_/wr_ is served as a read, so the write needs rd_ high.
  assign w_wr_en      = (r_state == S_XFER) && !bus.wr_ && bus.rd_ && !r_done && !bus.ale;
  assign w_xfer_entry = (w_next == S_XFER) && (r_state != S_XFER);

  // Drive only in the read data phase and never while the core owns AD for the address.
  assign w_oe     = (r_state == S_XFER) && !bus.rd_ && !bus.ale;
  assign addrdata = w_oe ? r_rdat : 8'hzz;

  assign bus.adrlat = r_adrlat;
  assign bus.sel    = r_sel;
`ifdef BUS85MEM_WAIT_EN
  assign bus.ready  = r_ready;
`else
  assign bus.ready  = 1'b1;
`endif

  // Next-state decode; ALE restarts the cycle from any state.
  always_comb begin
    w_next = r_state;
`ifdef BUS85MEM_WAIT_EN
    w_cnt_next = r_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        w_next = S_IDLE;
      end
      S_ADDR: begin
        if (!r_sel) begin
          w_next = S_IDLE;
        end else if (w_strobe) begin
`ifdef BUS85MEM_WAIT_EN
          if (WAITCYC == 0) begin
            w_next = S_XFER;
          end else begin
            w_next     = S_WAIT;
            w_cnt_next = WAIT_LOAD;
          end
`else
          w_next = S_XFER;
`endif
        end else begin
          w_next = S_ADDR;
        end
      end
`ifdef BUS85MEM_WAIT_EN
      S_WAIT: begin
        if (!w_strobe) begin
          w_next = S_IDLE;
        end else if (r_cnt == 4'd0) begin
          w_next = S_XFER;
        end else begin
          w_next     = S_WAIT;
          w_cnt_next = r_cnt - 4'd1;
        end
      end
`endif
      S_XFER: begin
        if (!w_strobe) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_XFER;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    if (bus.ale) begin
      w_next = S_ADDR;
    end else begin
      w_next = w_next;
    end
  end

  // State, address latch, select, single-write flag and READY registers.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state  <= S_IDLE;
      r_adrlat <= 16'h0000;
      r_sel    <= 1'b0;
      r_done   <= 1'b0;
`ifdef BUS85MEM_WAIT_EN
      r_cnt    <= 4'd0;
      r_ready  <= 1'b1;
`endif
    end else begin
      r_state <= w_next;
      if (bus.ale) begin
        r_adrlat <= w_adr_in;
        r_sel    <= w_sel_in;
        r_done   <= 1'b0;
      end else if (w_wr_en) begin
        r_done   <= 1'b1;
      end
`ifdef BUS85MEM_WAIT_EN
      r_cnt   <= w_cnt_next;
      r_ready <= (w_next != S_WAIT);
`endif
    end
  end

  // Byte array and read-data capture; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_idx] <= addrdata;
    end
    if (w_xfer_entry) begin
      r_rdat <= r_mem[w_idx];
    end
  end

endmodule
